perf_event_counters: RTL and testbench
======================================

// Module: perf_event_counters
// PURPOSE
//  Synthesizable, parametrised bank of hardware event counters. It replaces the bench-only
//  inst/ICache/DCache hit/req tallies with on-chip counters readable by the debug port.
//  Sits beside proc and takes one-cycle event pulses: RegWrite|MemWrite|Halt, cache req/hit.
//  Atomic snapshot into shadow registers; indexed read port; overflow tracking per channel.
// PARAMETERS
//  NUM_CH    6   number of event channels (1..16); ch0 conventionally = cycle count (tie ev[0]=1)
//  CNT_W     32  counter width in bits (8..64)
//  SEL_W     4   read-select width; must satisfy 2**SEL_W >= NUM_CH
//  SATURATE  0   0: counter wraps to 0 on overflow; 1: counter holds at all-ones
//  IRQ_CH    1   channel compared against thr (only with PERF_IRQ_EN)
// PORTS
//  clk      in   1        clock, all state on rising edge
//  rst      in   1        asynchronous reset, active-low
//  ev       in   NUM_CH   per-channel event pulse, counted once per cycle high
//  start    in   1        pulse: IDLE -> RUN
//  stop     in   1        pulse: RUN -> IDLE (counters retained)
//  clear    in   1        pulse: zero live/shadow counters and ovf, go IDLE
//  halt     in   1        processor halt seen; freezes counting
//  snap     in   1        pulse: copy all live counters into shadow registers
//  rd_req   in   1        read request, sampled every cycle
//  rd_sel   in   SEL_W    channel index for read
//  rd_ack   out  1        one-cycle pulse, read data valid
//  rd_data  out  CNT_W    shadow[rd_sel] captured at the request edge
//  rd_ovf   out  1        ovf[rd_sel] captured at the request edge
//  ovf      out  NUM_CH   sticky per-channel overflow flags
//  state    out  2        00 IDLE, 01 RUN, 10 HALTED
//  thr      in   CNT_W    irq threshold (PERF_IRQ_EN only)
//  irq      out  1        sticky threshold interrupt (PERF_IRQ_EN only)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; live, shadow, ovf, rd_data, rd_ovf, rd_ack, irq all 0.
//  FSM, priority clear > halt > stop > start within one cycle:
//   IDLE: start -> RUN; halt ignored.  RUN: halt -> HALTED; stop -> IDLE.
//   HALTED: only clear leaves (-> IDLE); start/stop ignored.  clear in any state -> IDLE.
//  Counting: live[i] increments by 1 at edge iff state==RUN and ev[i]=1 and no clear.
//   Event on the same cycle halt/stop is asserted IS counted (halt instruction counted).
//   Event on the same cycle as start is NOT counted (state still IDLE that edge).
//  Overflow: increment from all-ones -> SATURATE=0: wrap to 0; SATURATE=1: hold all-ones.
//   Either way ovf[i] sets and stays set until clear or reset.
//  Snapshot: on snap, shadow[i] <= live[i] pre-increment value for that edge, all channels same
//   edge. snap with clear: clear wins, shadow = 0.
//  Read: rd_req high at edge E -> rd_ack=1, rd_data/rd_ovf valid for the cycle after E.
//   Sampled value = shadow before any snap at E. Fully pipelined: rd_req held N cycles gives N acks.
//   rd_sel >= NUM_CH -> rd_data=0, rd_ovf=0, still acked. No rd_req -> rd_ack=0, data held.
//  Reset mid-operation: everything returns to reset values immediately; a pending ack is dropped.
// CONFIGURATION
//  `define PERF_IRQ_EN present: thr/irq ports exist; irq sets on the edge live[IRQ_CH]
//   becomes equal to thr while RUN; sticky until clear/reset; thr=0 never fires.
//  Absent: thr and irq ports omitted, no comparator logic generated.
// TESTING
//  Reset then start, ev=6'b000011 for 10 cycles, stop, snap, read ch0/ch1/ch2 -> 10,10,0, acks 1 cycle later.
//  CNT_W=8 SATURATE=0: 257 events on ch3 -> live=1, ovf[3]=1; SATURATE=1 -> live=255, ovf[3]=1.
//  RUN, ev[1]=1 with halt same cycle -> ch1 counts that cycle, state=HALTED; start ignored; clear -> IDLE, all 0.
//  snap and rd_req(sel=2) on same edge -> rd_data = old shadow; next read returns new value.
//  rd_req held 4 cycles, sel=0,1,2,7 (NUM_CH=6) -> 4 consecutive acks, last rd_data=0.
//  PERF_IRQ_EN, thr=5, IRQ_CH=1: 5th ch1 event -> irq=1 next cycle, remains 1 until clear.

Source files
------------

// File: rtl/perf_event_counters.sv
// Bank of per-channel event counters with run/halt control, atomic shadow snapshot and an indexed read port.
// Optional threshold interrupt on one channel is built when PERF_IRQ_EN is defined.

module perf_ctr_lane #(
    parameter int CNT_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             snap,
    output logic [CNT_W-1:0] live,
    output logic [CNT_W-1:0] shadow,
    output logic             ovf
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live   <= '0;
            shadow <= '0;
            ovf    <= 1'b0;
        end else if (clr) begin
            live   <= '0;
            shadow <= '0;
            ovf    <= 1'b0;
        end else begin
            // shadow takes the value before this edge's increment
            if (snap) shadow <= live;
            if (inc) begin
                if (&live) begin
                    ovf  <= 1'b1;
                    live <= (SATURATE != 0) ? live : '0;
                end else begin
                    live <= live + CNT_W'(1);
                end
            end
        end
    end
endmodule

module perf_event_counters #(
    parameter int NUM_CH   = 6,
    parameter int CNT_W    = 32,
    parameter int SEL_W    = 4,
    parameter int SATURATE = 0,
    parameter int IRQ_CH   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ev,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              halt,
    input  logic              snap,
    input  logic              rd_req,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic              rd_ack,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_ovf,
    output logic [NUM_CH-1:0] ovf,
    output logic [1:0]        state
`ifdef PERF_IRQ_EN
    ,
    input  logic [CNT_W-1:0]  thr,
    output logic              irq
`endif
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALTED = 2'b10} state_t;

    state_t stateQ;
    logic   run;
    logic [NUM_CH-1:0][CNT_W-1:0] live;
    logic [NUM_CH-1:0][CNT_W-1:0] shadow;
    logic [CNT_W-1:0] rdMux;
    logic             rdOvfMux;

    if (NUM_CH > 2**SEL_W || IRQ_CH >= NUM_CH || NUM_CH < 1) begin : gParamErr
        $error("perf_event_counters: illegal NUM_CH/SEL_W/IRQ_CH");
    end

    assign run   = (stateQ == RUN) && !clear;
    assign state = stateQ;

    for (genvar i = 0; i < NUM_CH; i++) begin : gLane
        perf_ctr_lane #(.CNT_W(CNT_W), .SATURATE(SATURATE)) uLane (
            .clk   (clk),
            .rst   (rst),
            .inc   (run & ev[i]),
            .clr   (clear),
            .snap  (snap),
            .live  (live[i]),
            .shadow(shadow[i]),
            .ovf   (ovf[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= IDLE;
        end else if (clear) begin
            stateQ <= IDLE;
        end else begin
            case (stateQ)
                IDLE:    if (start) stateQ <= RUN;
                RUN:     if (halt) stateQ <= HALTED;
                         else if (stop) stateQ <= IDLE;
                default: stateQ <= HALTED;
            endcase
        end
    end

    // out-of-range selects fall through to zero
    always_comb begin
        rdMux    = '0;
        rdOvfMux = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rdMux    = shadow[i];
                rdOvfMux = ovf[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ack  <= 1'b0;
            rd_data <= '0;
            rd_ovf  <= 1'b0;
        end else begin
            rd_ack <= rd_req;
            if (rd_req) begin
                rd_data <= rdMux;
                rd_ovf  <= rdOvfMux;
            end
        end
    end

`ifdef PERF_IRQ_EN
    logic [CNT_W-1:0] irqNxt;
    assign irqNxt = live[IRQ_CH] + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       irq <= 1'b0;
        else if (clear) irq <= 1'b0;
        else if (run && ev[IRQ_CH] && (thr != '0) && (irqNxt == thr)) irq <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_perf_event_counters.sv
// Drives a wrapping and a saturating 8-bit counter bank with the same stimulus and
// compares both against a per-cycle behavioural model.

module tb_perf_event_counters;
    localparam int NCH  = 6;
    localparam int W    = 8;
    localparam int MAXV = 255;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NCH-1:0] ev = '0;
    logic start = 0, stop = 0, clear = 0, halt = 0, snap = 0, rdReq = 0;
    logic [3:0] rdSel = '0;
    logic [W-1:0] thr = '0;

    logic [1:0]          rdAck, rdOvf, irq;
    logic [1:0][W-1:0]   rdData;
    logic [1:0][NCH-1:0] ovf;
    logic [1:0][1:0]     state;

    int checks = 0;
    int failures = 0;

    int mState[2];
    int mLive[2][NCH];
    int mShadow[2][NCH];
    bit mOvf[2][NCH];
    bit mAck[2];
    int mData[2];
    bit mROvf[2];
    bit mIrq[2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : gDut
        perf_event_counters #(.NUM_CH(NCH), .CNT_W(W), .SEL_W(4), .SATURATE(k), .IRQ_CH(1)) dut (
            .clk(clk), .rst(rst), .ev(ev), .start(start), .stop(stop), .clear(clear),
            .halt(halt), .snap(snap), .rd_req(rdReq), .rd_sel(rdSel),
            .rd_ack(rdAck[k]), .rd_data(rdData[k]), .rd_ovf(rdOvf[k]),
            .ovf(ovf[k]), .state(state[k])
`ifdef PERF_IRQ_EN
            , .thr(thr), .irq(irq[k])
`endif
        );
`ifndef PERF_IRQ_EN
        assign irq[k] = 1'b0;
`endif
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mState[k] = 0; mAck[k] = 0; mData[k] = 0; mROvf[k] = 0; mIrq[k] = 0;
            for (int i = 0; i < NCH; i++) begin
                mLive[k][i] = 0; mShadow[k][i] = 0; mOvf[k][i] = 0;
            end
        end
    endtask

    // one clock edge of behaviour, from the documented rules
    task automatic modelStep();
        int s;
        s = int'(rdSel);
        for (int k = 0; k < 2; k++) begin
            mAck[k] = rdReq;
            if (rdReq) begin
                mData[k] = 0; mROvf[k] = 0;
                if (s < NCH) begin mData[k] = mShadow[k][s]; mROvf[k] = mOvf[k][s]; end
            end
            if (clear) begin
                mState[k] = 0; mIrq[k] = 0;
                for (int i = 0; i < NCH; i++) begin
                    mLive[k][i] = 0; mShadow[k][i] = 0; mOvf[k][i] = 0;
                end
            end else begin
                if (snap) for (int i = 0; i < NCH; i++) mShadow[k][i] = mLive[k][i];
                if (mState[k] == 1) begin
                    for (int i = 0; i < NCH; i++) if (ev[i]) begin
                        if (mLive[k][i] == MAXV) begin
                            mOvf[k][i] = 1;
                            mLive[k][i] = (k == 1) ? MAXV : 0;
                        end else begin
                            mLive[k][i]++;
`ifdef PERF_IRQ_EN
                            if (i == 1 && thr != 0 && mLive[k][i] == int'(thr)) mIrq[k] = 1;
`endif
                        end
                    end
                end
                case (mState[k])
                    0: if (start) mState[k] = 1;
                    1: if (halt) mState[k] = 2; else if (stop) mState[k] = 0;
                    default: mState[k] = 2;
                endcase
            end
        end
    endtask

    task automatic checkAll();
        logic [NCH-1:0] eo;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NCH; i++) eo[i] = mOvf[k][i];
            chk($sformatf("state%0d", k), 64'(state[k]), 64'(mState[k]));
            chk($sformatf("ovf%0d", k), 64'(ovf[k]), 64'(eo));
            chk($sformatf("rdAck%0d", k), 64'(rdAck[k]), 64'(mAck[k]));
            chk($sformatf("rdData%0d", k), 64'(rdData[k]), 64'(mData[k]));
            chk($sformatf("rdOvf%0d", k), 64'(rdOvf[k]), 64'(mROvf[k]));
`ifdef PERF_IRQ_EN
            chk($sformatf("irq%0d", k), 64'(irq[k]), 64'(mIrq[k]));
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1 checkAll();
    endtask

    task automatic idleIn();
        ev = '0; start = 0; stop = 0; clear = 0; halt = 0; snap = 0; rdReq = 0;
    endtask

    task automatic rd(input int sel);
        rdReq = 1; rdSel = 4'(sel);
        tick();
        rdReq = 0;
    endtask

    task automatic pulse(input string which);
        idleIn();
        case (which)
            "start": start = 1;
            "stop":  stop = 1;
            "clear": clear = 1;
            "snap":  snap = 1;
            default: ;
        endcase
        tick();
        idleIn();
    endtask

    initial begin
        modelReset();
        #2 checkAll();
        @(posedge clk); #1 rst = 1;

        // basic count: start cycle itself not counted
        pulse("start");
        ev = 6'b000011;
        repeat (10) tick();
        pulse("stop");
        pulse("snap");
        rd(0); chk("cnt_ch0_a", 64'(rdData[0]), 10); chk("cnt_ch0_b", 64'(rdData[1]), 10);
        chk("ack_ch0", 64'(rdAck[0]), 1);
        rd(1); chk("cnt_ch1", 64'(rdData[0]), 10);
        rd(2); chk("cnt_ch2", 64'(rdData[0]), 0);
        tick(); chk("ack_drop", 64'(rdAck[0]), 0);

        // overflow: 257 events on ch3
        pulse("clear"); pulse("start");
        ev = 6'b001000;
        repeat (257) tick();
        pulse("stop"); pulse("snap");
        rd(3);
        chk("wrap_val", 64'(rdData[0]), 1);
        chk("sat_val", 64'(rdData[1]), 255);
        chk("wrap_ovf", 64'(rdOvf[0]), 1);
        chk("sat_ovf3", 64'(ovf[1][3]), 1);

        // halt on same cycle as an event
        pulse("clear"); pulse("start");
        ev = 6'b000010; tick();
        halt = 1; tick(); idleIn();
        chk("halted", 64'(state[0]), 2);
        pulse("start"); chk("halt_start_ign", 64'(state[0]), 2);
        pulse("stop");  chk("halt_stop_ign", 64'(state[0]), 2);
        pulse("snap"); rd(1); chk("halt_counted", 64'(rdData[0]), 2);
        pulse("clear"); chk("clear_idle", 64'(state[0]), 0);
        rd(1); chk("clear_shadow", 64'(rdData[0]), 0);

        // snap and read on the same edge
        pulse("start"); ev = 6'b000100; repeat (3) tick();
        pulse("stop"); pulse("snap");
        pulse("start"); ev = 6'b000100; repeat (2) tick();
        pulse("stop");
        snap = 1; rdReq = 1; rdSel = 4'd2; tick(); idleIn();
        chk("snap_rd_old", 64'(rdData[0]), 3);
        rd(2); chk("snap_rd_new", 64'(rdData[0]), 5);

        // back-to-back reads including an out-of-range select
        rdReq = 1;
        rdSel = 4'd0; tick(); chk("pipe_ack0", 64'(rdAck[0]), 1);
        rdSel = 4'd1; tick(); chk("pipe_ack1", 64'(rdAck[0]), 1);
        rdSel = 4'd2; tick(); chk("pipe_ack2", 64'(rdAck[0]), 1);
        rdSel = 4'd7; tick(); chk("pipe_ack3", 64'(rdAck[0]), 1);
        chk("oob_data", 64'(rdData[0]), 0);
        idleIn(); tick();

`ifdef PERF_IRQ_EN
        thr = 8'd5;
        pulse("clear"); pulse("start");
        ev = 6'b000010; repeat (4) tick();
        chk("irq_pre", 64'(irq[0]), 0);
        tick(); chk("irq_fire", 64'(irq[0]), 1);
        repeat (3) tick(); chk("irq_sticky", 64'(irq[0]), 1);
        pulse("clear"); chk("irq_clear", 64'(irq[0]), 0);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ev    = 6'($urandom);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            clear = ($urandom_range(0, 127) == 0);
            halt  = ($urandom_range(0, 63) == 0);
            snap  = ($urandom_range(0, 7) == 0);
            rdReq = ($urandom_range(0, 1) == 0);
            rdSel = 4'($urandom_range(0, 7));
            if (n % 500 == 0) thr = 8'($urandom_range(0, 20));
            tick();
        end

        // asynchronous reset with a read in flight
        idleIn(); rdReq = 1; rdSel = 4'd1; tick();
        #2 rst = 0;
        #1 modelReset(); checkAll();
        chk("rst_ack", 64'(rdAck[0]), 0);
        idleIn();
        @(posedge clk); #1 checkAll();
        rst = 1;
        pulse("start"); ev = 6'b111111; repeat (3) tick();
        pulse("snap"); rd(5); chk("post_rst_cnt", 64'(rdData[0]), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
